fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
// Parametrised operand-forwarding and hazard unit for the RV32I_Zicsr pipeline. It selects
// EX-stage operands from NUM_FWD younger-writer stages and detects load-use hazards in ID.
// It stalls IF/ID for a configurable load latency and holds EX when a matching writer's data
// is not ready. It sits between the ID/EX pipeline register and the ALU operand muxes.
// PARAMETERS
// XLEN      32  data width
// XADDR     5   register address width; address 0 (x0) is never forwarded or hazarded
// NUM_SRC   2   source operands per instruction
// NUM_FWD   2   forwarding stages; index 0 = youngest (MEM), NUM_FWD-1 = oldest (WB)
// LOAD_LAT  1   stall cycles per load-use hazard, >=1
// CNT_W     16  width of the stall performance counter
// PORTS
// i_clk         in   1               clock
// i_rst_n       in   1               asynchronous active-low reset
// i_src_addr_ex in   NUM_SRC*XADDR   EX source register addresses, operand s at [s*XADDR+:XADDR]
// i_src_data_ex in   NUM_SRC*XLEN    EX register-file read values
// i_fwd_addr    in   NUM_FWD*XADDR   rd address per forwarding stage
// i_fwd_data    in   NUM_FWD*XLEN    rd value per forwarding stage
// i_fwd_wr_en   in   NUM_FWD         stage writes the register file
// i_fwd_rdy     in   NUM_FWD         stage rd value is valid; 0 = data pending, e.g. load miss
// i_src_addr_id in   NUM_SRC*XADDR   ID source register addresses
// i_src_used_id in   NUM_SRC         ID instruction actually reads operand s
// i_ex_is_load  in   1               EX instruction is a load
// i_ex_rd_addr  in   XADDR           EX instruction rd
// i_flush       in   1               branch/trap redirect; kills ID and EX
// o_src_data    out  NUM_SRC*XLEN    forwarded operands to ALU
// o_stall       out  1               hold PC and IF/ID
// o_bubble      out  1               inject NOP into ID/EX
// o_hold_ex     out  1               hold EX; pipeline injects bubble into MEM
// o_stall_cnt   out  CNT_W           saturating count of cycles with o_stall=1
// BEHAVIOUR
// - Forwarding is combinational. For operand s, the lowest-index stage k with i_fwd_wr_en[k],
//   address match and address!=0 is selected. If that stage has i_fwd_rdy[k]=1, o_src_data[s]
//   is i_fwd_data[k]. Otherwise i_src_data_ex[s] passes through and the operand is pending.
//   With no match, i_src_data_ex[s] passes through; x0 always passes i_src_data_ex.
// - Only the youngest matching stage is considered: an older ready stage never overrides
//   a younger pending one.
// - o_hold_ex = any operand pending. When o_hold_ex=1: o_stall=1 and o_bubble=0.
// - Load-use is detected when i_ex_is_load, i_ex_rd_addr!=0, and some s has
//   i_src_used_id[s] and i_src_addr_id[s]==i_ex_rd_addr.
// - FSM states: RUN, LOAD_WAIT. Down-counter cnt has width clog2(LOAD_LAT+1).
//   RUN: on load-use (and no i_flush, no o_hold_ex), o_stall=o_bubble=1 in the same cycle.
//   If LOAD_LAT>1, go to LOAD_WAIT with cnt=LOAD_LAT-1.
//   LOAD_WAIT: o_stall=o_bubble=1; cnt decrements each cycle; at cnt==1, return to RUN next
//   cycle. The stall length is exactly LOAD_LAT cycles.
// - o_hold_ex=1 in LOAD_WAIT freezes cnt and the state; o_bubble is then 0.
// - i_flush has priority over everything. The FSM goes to RUN, cnt=0, and o_stall=o_bubble=0
//   in the flush cycle. o_hold_ex is unaffected, since EX-side pending data belongs to older
//   instructions.
// - o_stall_cnt increments each cycle o_stall=1 and saturates at all-ones (no wrap).
// - Reset (async assert, sync-safe deassert by system): state RUN, cnt 0, o_stall_cnt 0.
//   While i_rst_n=0, o_stall, o_bubble and o_hold_ex are forced 0.
//   Reset mid-LOAD_WAIT abandons the stall immediately.
// STRUCTURE
// - header.vh gains `FWD_RUN/`FWD_LOAD_WAIT state encodings and a `CLOG2 macro.
//   XLEN/XADDR defaults come from the existing `XLEN/`XADDR.
// - One sub-module: fwd_operand_sel (one operand: priority match across NUM_FWD stages,
//   outputs data and pending). It is instantiated NUM_SRC times via generate.
// TESTING
// - MEM wr x5=0xA, WB wr x5=0xB, EX rs1=x5, rs2=x6 (rf 0x3) -> o_src_data: 0xA, 0x3; no stall.
// - Match on x0 in MEM with wr_en=1, data 0xFF -> operand = i_src_data_ex (0); hold_ex=0.
// - LOAD_LAT=3, EX load rd=x7, ID uses rs2=x7 -> o_stall=o_bubble=1 exactly 3 cycles;
//   o_stall_cnt=3. ID using x7 with i_src_used_id=0 -> no stall.
// - MEM wr x9 rdy=0, WB wr x9 rdy=1, EX rs1=x9 -> o_hold_ex=1, o_stall=1, o_bubble=0.
//   When rdy rises, the MEM value is forwarded and hold drops in the same cycle.
// - LOAD_LAT=3, i_flush in the 2nd stall cycle -> stall drops that cycle, FSM RUN.
//   Reset asserted in LOAD_WAIT -> all outputs 0 at once.
// - CNT_W=4, force 20 stall cycles -> o_stall_cnt holds at 15.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared defaults, FSM state type and sizing helper for the forwarding/hazard unit.
package fwd_hazard_unit_pkg;

    localparam int unsigned DEF_XLEN     = 32;
    localparam int unsigned DEF_XADDR    = 5;
    localparam int unsigned DEF_NUM_SRC  = 2;
    localparam int unsigned DEF_NUM_FWD  = 2;
    localparam int unsigned DEF_LOAD_LAT = 1;
    localparam int unsigned DEF_CNT_W    = 16;

    typedef enum logic [0:0] {
        ST_RUN       = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } fwd_state_e;

    // Width of the load-latency down-counter; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle of the forwarding/hazard unit.
// master: pipeline (drives i_* request fields, receives o_* results)
// slave : fwd_hazard_unit
interface fwd_hazard_unit_if
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned XLEN    = DEF_XLEN,
    parameter int unsigned XADDR   = DEF_XADDR,
    parameter int unsigned NUM_SRC = DEF_NUM_SRC,
    parameter int unsigned NUM_FWD = DEF_NUM_FWD,
    parameter int unsigned CNT_W   = DEF_CNT_W
) ();

    logic [NUM_SRC*XADDR-1:0] i_src_addr_ex;
    logic [NUM_SRC*XLEN-1:0]  i_src_data_ex;
    logic [NUM_FWD*XADDR-1:0] i_fwd_addr;
    logic [NUM_FWD*XLEN-1:0]  i_fwd_data;
    logic [NUM_FWD-1:0]       i_fwd_wr_en;
    logic [NUM_FWD-1:0]       i_fwd_rdy;
    logic [NUM_SRC*XADDR-1:0] i_src_addr_id;
    logic [NUM_SRC-1:0]       i_src_used_id;
    logic                     i_ex_is_load;
    logic [XADDR-1:0]         i_ex_rd_addr;
    logic                     i_flush;
    logic [NUM_SRC*XLEN-1:0]  o_src_data;
    logic                     o_stall;
    logic                     o_bubble;
    logic                     o_hold_ex;
    logic [CNT_W-1:0]         o_stall_cnt;

    modport master (
        output i_src_addr_ex, i_src_data_ex, i_fwd_addr, i_fwd_data, i_fwd_wr_en,
               i_fwd_rdy, i_src_addr_id, i_src_used_id, i_ex_is_load, i_ex_rd_addr, i_flush,
        input  o_src_data, o_stall, o_bubble, o_hold_ex, o_stall_cnt
    );

    modport slave (
        input  i_src_addr_ex, i_src_data_ex, i_fwd_addr, i_fwd_data, i_fwd_wr_en,
               i_fwd_rdy, i_src_addr_id, i_src_used_id, i_ex_is_load, i_ex_rd_addr, i_flush,
        output o_src_data, o_stall, o_bubble, o_hold_ex, o_stall_cnt
    );

endinterface

// File: rtl/fwd_operand_sel.sv
// One EX operand: picks the youngest writing stage whose rd matches the source.
// Ports: src_addr/src_data (register-file read), fwd_* (per-stage rd, value, write, ready),
//        data_c (selected operand), pending_c (youngest match has no data yet).
module fwd_operand_sel
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned XLEN    = DEF_XLEN,
    parameter int unsigned XADDR   = DEF_XADDR,
    parameter int unsigned NUM_FWD = DEF_NUM_FWD
) (
    input  logic [XADDR-1:0]         src_addr,
    input  logic [XLEN-1:0]          src_data,
    input  logic [NUM_FWD*XADDR-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]  fwd_data,
    input  logic [NUM_FWD-1:0]       fwd_wr_en,
    input  logic [NUM_FWD-1:0]       fwd_rdy,
    output logic [XLEN-1:0]          data_c,
    output logic                     pending_c
);

    logic found;

    // First hit wins, so an older ready stage can never mask a younger pending one.
    always_comb begin
        data_c    = src_data;
        pending_c = 1'b0;
        found     = 1'b0;
        for (int k = 0; k < int'(NUM_FWD); k++) begin
            if (!found && fwd_wr_en[k] && (src_addr != '0) &&
                (fwd_addr[k*XADDR +: XADDR] == src_addr)) begin
                found = 1'b1;
                if (fwd_rdy[k]) begin
                    data_c = fwd_data[k*XLEN +: XLEN];
                end else begin
                    pending_c = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, EX hold on pending writer data, and load-use stall of IF/ID.
// Ports: i_clk, i_rst_n (async active-low); bus (slave) carries operand addresses/data,
//        forwarding-stage info, ID hazard inputs, flush, and the stall/bubble/hold results
//        plus a saturating stall-cycle counter.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned XLEN     = DEF_XLEN,
    parameter int unsigned XADDR    = DEF_XADDR,
    parameter int unsigned NUM_SRC  = DEF_NUM_SRC,
    parameter int unsigned NUM_FWD  = DEF_NUM_FWD,
    parameter int unsigned LOAD_LAT = DEF_LOAD_LAT,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    fwd_hazard_unit_if.slave bus
);

    localparam int unsigned CW = cnt_width(LOAD_LAT);

    fwd_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [NUM_SRC-1:0] pending;
    logic              hold_c;
    logic              load_use_c;
    logic              stall_c;
    logic              bubble_c;

    // Per-operand forwarding muxes.
    for (genvar s = 0; s < int'(NUM_SRC); s++) begin : g_src
        fwd_operand_sel #(
            .XLEN    (XLEN),
            .XADDR   (XADDR),
            .NUM_FWD (NUM_FWD)
        ) u_sel (
            .src_addr  (bus.i_src_addr_ex[s*XADDR +: XADDR]),
            .src_data  (bus.i_src_data_ex[s*XLEN +: XLEN]),
            .fwd_addr  (bus.i_fwd_addr),
            .fwd_data  (bus.i_fwd_data),
            .fwd_wr_en (bus.i_fwd_wr_en),
            .fwd_rdy   (bus.i_fwd_rdy),
            .data_c    (bus.o_src_data[s*XLEN +: XLEN]),
            .pending_c (pending[s])
        );
    end

    assign hold_c = |pending;

    // ID reads the register an in-flight EX load is about to write.
    always_comb begin
        load_use_c = 1'b0;
        if (bus.i_ex_is_load && (bus.i_ex_rd_addr != '0)) begin
            for (int s = 0; s < int'(NUM_SRC); s++) begin
                if (bus.i_src_used_id[s] &&
                    (bus.i_src_addr_id[s*XADDR +: XADDR] == bus.i_ex_rd_addr)) begin
                    load_use_c = 1'b1;
                end
            end
        end
    end

    // Load-use FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and stall/bubble decode; flush beats EX hold, which beats the load stall.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        if (bus.i_flush) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else if (hold_c) begin
            stall_c = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (load_use_c) begin
                        stall_c  = 1'b1;
                        bubble_c = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = ST_LOAD_WAIT;
                            cnt_d   = CW'(LOAD_LAT - 1);
                        end
                    end
                end
                ST_LOAD_WAIT: begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Control outputs are held low for the whole reset assertion.
    assign bus.o_stall     = i_rst_n & stall_c;
    assign bus.o_bubble    = i_rst_n & bubble_c;
    assign bus.o_hold_ex   = i_rst_n & hold_c;
    assign bus.o_stall_cnt = stall_cnt_q;

    // Saturating stall-cycle performance counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit (LOAD_LAT=3, CNT_W=4).
module tb_fwd_hazard_unit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned XADDR = 5;

    typedef struct packed {
        logic        chk_data;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        chk_ctl;
        logic        stall;
        logic        bubble;
        logic        hold;
        logic        chk_cnt;
        logic [3:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    exp_t  exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(
        .XLEN(32), .XADDR(5), .NUM_SRC(2), .NUM_FWD(2), .CNT_W(4)
    ) bus ();

    fwd_hazard_unit #(
        .XLEN(32), .XADDR(5), .NUM_SRC(2), .NUM_FWD(2), .LOAD_LAT(3), .CNT_W(4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_src_addr_ex = '0;
        bus.i_src_data_ex = '0;
        bus.i_fwd_addr    = '0;
        bus.i_fwd_data    = '0;
        bus.i_fwd_wr_en   = '0;
        bus.i_fwd_rdy     = '0;
        bus.i_src_addr_id = '0;
        bus.i_src_used_id = '0;
        bus.i_ex_is_load  = 1'b0;
        bus.i_ex_rd_addr  = '0;
        bus.i_flush       = 1'b0;
    endtask

    task automatic set_fwd(input int k, input logic [4:0] a, input logic [31:0] d,
                           input logic wr, input logic rdy);
        bus.i_fwd_addr[k*XADDR +: XADDR] = a;
        bus.i_fwd_data[k*XLEN +: XLEN]   = d;
        bus.i_fwd_wr_en[k]               = wr;
        bus.i_fwd_rdy[k]                 = rdy;
    endtask

    task automatic set_src(input int s, input logic [4:0] a, input logic [31:0] d);
        bus.i_src_addr_ex[s*XADDR +: XADDR] = a;
        bus.i_src_data_ex[s*XLEN +: XLEN]   = d;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input int s, input logic used);
        bus.i_ex_is_load                    = 1'b1;
        bus.i_ex_rd_addr                    = rd;
        bus.i_src_addr_id[s*XADDR +: XADDR] = rd;
        bus.i_src_used_id[s]                = used;
    endtask

    // Push expectations for the current cycle; the monitor checks them mid-cycle.
    task automatic exp_ctl(input string nm, input logic st, input logic bb, input logic hd,
                           input logic [3:0] cn);
        exp_t e;
        e = '0;
        e.chk_ctl = 1'b1; e.stall = st; e.bubble = bb; e.hold = hd;
        e.chk_cnt = 1'b1; e.cnt = cn;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic exp_all(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                           input logic st, input logic bb, input logic hd,
                           input logic [3:0] cn);
        exp_t e;
        e = '0;
        e.chk_data = 1'b1; e.d0 = d0; e.d1 = d1;
        e.chk_ctl = 1'b1; e.stall = st; e.bubble = bb; e.hold = hd;
        e.chk_cnt = 1'b1; e.cnt = cn;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    // Monitor: the unit answers every cycle, so each mid-cycle sample retires one entry.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.chk_data) begin
                cmp(nm, "src0", bus.o_src_data[31:0], e.d0);
                cmp(nm, "src1", bus.o_src_data[63:32], e.d1);
            end
            if (e.chk_ctl) begin
                cmp(nm, "stall",  32'(bus.o_stall),   32'(e.stall));
                cmp(nm, "bubble", 32'(bus.o_bubble),  32'(e.bubble));
                cmp(nm, "hold",   32'(bus.o_hold_ex), 32'(e.hold));
            end
            if (e.chk_cnt) begin
                cmp(nm, "cnt", 32'(bus.o_stall_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        tick();

        // Reset holds controls low even with a load-use hazard present.
        set_load_use(5'd7, 1, 1'b1);
        exp_ctl("reset", 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        clear_inputs();
        rst_n = 1'b1;
        tick();

        // MEM beats WB on x5; x6 has no writer.
        set_fwd(0, 5'd5, 32'hA, 1'b1, 1'b1);
        set_fwd(1, 5'd5, 32'hB, 1'b1, 1'b1);
        set_src(0, 5'd5, 32'h1111);
        set_src(1, 5'd6, 32'h3);
        exp_all("fwd_mem", 32'hA, 32'h3, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();

        // MEM not writing: WB supplies x5.
        bus.i_fwd_wr_en[0] = 1'b0;
        exp_all("fwd_wb", 32'hB, 32'h3, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();

        // x0 never forwarded.
        clear_inputs();
        set_fwd(0, 5'd0, 32'hFF, 1'b1, 1'b1);
        set_src(0, 5'd0, 32'h0);
        set_src(1, 5'd6, 32'h3);
        exp_all("fwd_x0", 32'h0, 32'h3, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();

        // Load rd matches ID but operand unused: no stall.
        clear_inputs();
        set_load_use(5'd7, 1, 1'b0);
        exp_ctl("lu_unused", 1'b0, 1'b0, 1'b0, 4'd0);
        tick();

        // Load-use: exactly three stall+bubble cycles.
        clear_inputs();
        set_load_use(5'd7, 1, 1'b1);
        exp_ctl("lu_c1", 1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        clear_inputs();
        exp_ctl("lu_c2", 1'b1, 1'b1, 1'b0, 4'd1);
        tick();
        exp_ctl("lu_c3", 1'b1, 1'b1, 1'b0, 4'd2);
        tick();
        exp_ctl("lu_done", 1'b0, 1'b0, 1'b0, 4'd3);
        tick();

        // Younger pending writer wins over older ready one.
        set_fwd(0, 5'd9, 32'h99, 1'b1, 1'b0);
        set_fwd(1, 5'd9, 32'h77, 1'b1, 1'b1);
        set_src(0, 5'd9, 32'h55);
        set_src(1, 5'd6, 32'h3);
        exp_all("hold_c1", 32'h55, 32'h3, 1'b1, 1'b0, 1'b1, 4'd3);
        tick();
        exp_all("hold_c2", 32'h55, 32'h3, 1'b1, 1'b0, 1'b1, 4'd4);
        tick();
        bus.i_fwd_rdy[0] = 1'b1;
        exp_all("hold_rdy", 32'h99, 32'h3, 1'b0, 1'b0, 1'b0, 4'd5);
        tick();

        // Flush in second stall cycle ends the stall immediately.
        clear_inputs();
        set_load_use(5'd7, 0, 1'b1);
        exp_ctl("fl_c1", 1'b1, 1'b1, 1'b0, 4'd5);
        tick();
        clear_inputs();
        bus.i_flush = 1'b1;
        exp_ctl("fl_c2", 1'b0, 1'b0, 1'b0, 4'd6);
        tick();
        clear_inputs();
        exp_ctl("fl_after", 1'b0, 1'b0, 1'b0, 4'd6);
        tick();

        // EX hold during LOAD_WAIT freezes the countdown.
        set_load_use(5'd7, 0, 1'b1);
        exp_ctl("frz_c1", 1'b1, 1'b1, 1'b0, 4'd6);
        tick();
        clear_inputs();
        set_fwd(0, 5'd3, 32'h1, 1'b1, 1'b0);
        set_src(0, 5'd3, 32'h2);
        exp_ctl("frz_hold", 1'b1, 1'b0, 1'b1, 4'd7);
        tick();
        clear_inputs();
        exp_ctl("frz_c2", 1'b1, 1'b1, 1'b0, 4'd8);
        tick();
        exp_ctl("frz_c3", 1'b1, 1'b1, 1'b0, 4'd9);
        tick();
        exp_ctl("frz_done", 1'b0, 1'b0, 1'b0, 4'd10);
        tick();

        // Reset asserted inside LOAD_WAIT clears everything at once.
        set_load_use(5'd7, 1, 1'b1);
        exp_ctl("rst_c1", 1'b1, 1'b1, 1'b0, 4'd10);
        tick();
        clear_inputs();
        exp_ctl("rst_c2", 1'b1, 1'b1, 1'b0, 4'd11);
        tick();
        set_fwd(0, 5'd3, 32'h1, 1'b1, 1'b0);
        set_src(0, 5'd3, 32'h2);
        rst_n = 1'b0;
        exp_ctl("rst_mid", 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        clear_inputs();
        rst_n = 1'b1;
        exp_ctl("rst_rel", 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        exp_ctl("rst_run", 1'b0, 1'b0, 1'b0, 4'd0);
        tick();

        // 20 held cycles saturate the 4-bit counter at 15.
        set_fwd(0, 5'd3, 32'h1, 1'b1, 1'b0);
        set_src(0, 5'd3, 32'h2);
        for (int i = 0; i < 20; i++) begin
            exp_ctl("sat", 1'b1, 1'b0, 1'b1, (i > 15) ? 4'd15 : 4'(i));
            tick();
        end
        clear_inputs();
        exp_ctl("sat_end", 1'b0, 1'b0, 1'b0, 4'd15);
        tick();
        exp_ctl("sat_hold", 1'b0, 1'b0, 1'b0, 4'd15);
        tick();

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
